// File: rtl/wb_pkg.sv
// Shared widths and queue-entry type for the register-file writeback arbiter.
package wb_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] wd;
    } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// Long-latency writeback FIFO: newest-value-per-register tracking, kill on pipeline
// rd match, and up to two in-order drains into free register-file ports.
module wb_queue
    import wb_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = ADDR_W,
    parameter int unsigned DATA_WIDTH    = DATA_W,
    parameter int unsigned QDEPTH        = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enq,
    input  logic [ADDRESS_WIDTH-1:0]    enq_rd,
    input  logic [DATA_WIDTH-1:0]       enq_wd,
    input  logic                        kill1_en,
    input  logic [ADDRESS_WIDTH-1:0]    kill1_rd,
    input  logic                        kill2_en,
    input  logic [ADDRESS_WIDTH-1:0]    kill2_rd,
    input  logic [1:0]                  free_cnt,
    output logic                        not_full,
    output logic [2**ADDRESS_WIDTH-1:0] pend_mask,
    output logic                        wr_a_en,
    output logic [ADDRESS_WIDTH-1:0]    wr_a_rd,
    output logic [DATA_WIDTH-1:0]       wr_a_wd,
    output logic                        wr_b_en,
    output logic [ADDRESS_WIDTH-1:0]    wr_b_rd,
    output logic [DATA_WIDTH-1:0]       wr_b_wd
);

    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = $clog2(QDEPTH + 1);

    wb_entry_t     mem_q [QDEPTH];
    wb_entry_t     mem_d [QDEPTH];
    logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d, rptr1;
    logic [CW-1:0] cnt_q, cnt_d;

    wb_entry_t h0, h1;
    logic      has0, has1, v0, v1, pop0, pop1, use0;
    logic [1:0] left;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic hit(input logic [ADDRESS_WIDTH-1:0] rd,
                                 input logic k1, input logic [ADDRESS_WIDTH-1:0] r1,
                                 input logic k2, input logic [ADDRESS_WIDTH-1:0] r2);
        return (k1 && rd == r1) || (k2 && rd == r2);
    endfunction

    assign not_full = cnt_q < CW'(QDEPTH);
    assign rptr1    = ptr_inc(rptr_q);

    always_comb begin
        h0   = mem_q[rptr_q];
        h1   = mem_q[rptr1];
        has0 = cnt_q != '0;
        has1 = cnt_q > CW'(1);
        v0   = has0 && h0.valid && !hit(h0.rd, kill1_en, kill1_rd, kill2_en, kill2_rd);
        v1   = has1 && h1.valid && !hit(h1.rd, kill1_en, kill1_rd, kill2_en, kill2_rd);
        // Dead entries leave the head without needing a port.
        pop0 = has0 && (!v0 || free_cnt != 2'd0);
        use0 = v0 && pop0;
        left = free_cnt - {1'b0, use0};
        pop1 = pop0 && has1 && (!v1 || left != 2'd0);

        wr_a_en = 1'b0;
        wr_a_rd = '0;
        wr_a_wd = '0;
        wr_b_en = 1'b0;
        wr_b_rd = '0;
        wr_b_wd = '0;
        if (use0) begin
            wr_a_en = 1'b1;
            wr_a_rd = h0.rd;
            wr_a_wd = h0.wd;
        end
        if (v1 && pop1) begin
            if (use0) begin
                wr_b_en = 1'b1;
                wr_b_rd = h1.rd;
                wr_b_wd = h1.wd;
            end else begin
                wr_a_en = 1'b1;
                wr_a_rd = h1.rd;
                wr_a_wd = h1.wd;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < QDEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (mem_q[i].valid &&
                (hit(mem_q[i].rd, kill1_en, kill1_rd, kill2_en, kill2_rd) ||
                 (enq && mem_q[i].rd == enq_rd))) begin
                mem_d[i].valid = 1'b0;
            end
        end
        if (pop0) mem_d[rptr_q].valid = 1'b0;
        if (pop1) mem_d[rptr1].valid  = 1'b0;
        if (enq) begin
            mem_d[wptr_q].valid = 1'b1;
            mem_d[wptr_q].rd    = enq_rd;
            mem_d[wptr_q].wd    = enq_wd;
        end
        rptr_d = pop1 ? ptr_inc(rptr1) : (pop0 ? rptr1 : rptr_q);
        wptr_d = enq ? ptr_inc(wptr_q) : wptr_q;
        cnt_d  = cnt_q + CW'(enq) - CW'(pop0) - CW'(pop1);
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (mem_q[i].valid) pend_mask[mem_q[i].rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int i = 0; i < QDEPTH; i++) mem_q[i] <= mem_d[i];
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Two-port register-file writeback arbiter: pipeline writes take priority, the
// long-latency queue fills whatever ports are left; all write ports registered.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = ADDR_W,
    parameter int unsigned DATA_WIDTH    = DATA_W,
    parameter int unsigned QDEPTH        = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        p1_we,
    input  logic [ADDRESS_WIDTH-1:0]    p1_rd,
    input  logic [DATA_WIDTH-1:0]       p1_wd,
    input  logic                        p2_we,
    input  logic [ADDRESS_WIDTH-1:0]    p2_rd,
    input  logic [DATA_WIDTH-1:0]       p2_wd,
    input  logic                        lu_valid,
    input  logic [ADDRESS_WIDTH-1:0]    lu_rd,
    input  logic [DATA_WIDTH-1:0]       lu_wd,
    output logic                        lu_ready,
    output logic                        WE3,
    output logic [ADDRESS_WIDTH-1:0]    AD3,
    output logic [DATA_WIDTH-1:0]       WD3,
    output logic                        WE6,
    output logic [ADDRESS_WIDTH-1:0]    AD6,
    output logic [DATA_WIDTH-1:0]       WD6,
    output logic [2**ADDRESS_WIDTH-1:0] pend_mask
);

    logic p1_eff, p2_eff, p1_use, lu_take, q_not_full;
    logic [1:0] free_cnt;
    logic                     wr_a_en, wr_b_en;
    logic [ADDRESS_WIDTH-1:0] wr_a_rd, wr_b_rd;
    logic [DATA_WIDTH-1:0]    wr_a_wd, wr_b_wd;

    logic                     we3_d, we3_q, we6_d, we6_q;
    logic [ADDRESS_WIDTH-1:0] ad3_d, ad3_q, ad6_d, ad6_q;
    logic [DATA_WIDTH-1:0]    wd3_d, wd3_q, wd6_d, wd6_q;

    assign p1_eff   = p1_we && (p1_rd != '0);
    assign p2_eff   = p2_we && (p2_rd != '0);
    // p2 is younger, so on an rd clash its value is the one that must survive.
    assign p1_use   = p1_eff && !(p2_eff && p1_rd == p2_rd);
    assign free_cnt = {1'b0, ~p1_use} + {1'b0, ~p2_eff};

    // Held low through reset so no offer is taken while the queue is being cleared.
    assign lu_ready = rst_n && q_not_full;
    assign lu_take  = lu_valid && lu_ready && (lu_rd != '0) &&
                      !(p1_eff && lu_rd == p1_rd) && !(p2_eff && lu_rd == p2_rd);

    wb_queue #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .QDEPTH        (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .enq       (lu_take),
        .enq_rd    (lu_rd),
        .enq_wd    (lu_wd),
        .kill1_en  (p1_eff),
        .kill1_rd  (p1_rd),
        .kill2_en  (p2_eff),
        .kill2_rd  (p2_rd),
        .free_cnt  (free_cnt),
        .not_full  (q_not_full),
        .pend_mask (pend_mask),
        .wr_a_en   (wr_a_en),
        .wr_a_rd   (wr_a_rd),
        .wr_a_wd   (wr_a_wd),
        .wr_b_en   (wr_b_en),
        .wr_b_rd   (wr_b_rd),
        .wr_b_wd   (wr_b_wd)
    );

    always_comb begin
        we3_d = 1'b0;
        ad3_d = '0;
        wd3_d = '0;
        we6_d = 1'b0;
        ad6_d = '0;
        wd6_d = '0;
        if (p1_use) begin
            we3_d = 1'b1;
            ad3_d = p1_rd;
            wd3_d = p1_wd;
        end else if (wr_a_en) begin
            we3_d = 1'b1;
            ad3_d = wr_a_rd;
            wd3_d = wr_a_wd;
        end
        if (p2_eff) begin
            we6_d = 1'b1;
            ad6_d = p2_rd;
            wd6_d = p2_wd;
        end else if (!p1_use && wr_b_en) begin
            we6_d = 1'b1;
            ad6_d = wr_b_rd;
            wd6_d = wr_b_wd;
        end else if (p1_use && wr_a_en) begin
            we6_d = 1'b1;
            ad6_d = wr_a_rd;
            wd6_d = wr_a_wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we3_q <= 1'b0;
            ad3_q <= '0;
            wd3_q <= '0;
            we6_q <= 1'b0;
            ad6_q <= '0;
            wd6_q <= '0;
        end else begin
            we3_q <= we3_d;
            ad3_q <= ad3_d;
            wd3_q <= wd3_d;
            we6_q <= we6_d;
            ad6_q <= ad6_d;
            wd6_q <= wd6_d;
        end
    end

    assign WE3 = we3_q;
    assign AD3 = ad3_q;
    assign WD3 = wd3_q;
    assign WE6 = we6_q;
    assign AD6 = ad6_q;
    assign WD6 = wd6_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: stimulus queues expected port writes, a
// negedge monitor pops and compares them cycle by cycle.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p1_we, p2_we, lu_valid;
    logic [4:0]  p1_rd, p2_rd, lu_rd;
    logic [31:0] p1_wd, p2_wd, lu_wd;
    logic        lu_ready, WE3, WE6;
    logic [4:0]  AD3, AD6;
    logic [31:0] WD3, WD6;
    logic [31:0] pend_mask;

    typedef struct {
        int          due;
        logic        we3;
        logic [4:0]  ad3;
        logic [31:0] wd3;
        logic        we6;
        logic [4:0]  ad6;
        logic [31:0] wd6;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    wb_arbiter #(
        .ADDRESS_WIDTH (5),
        .DATA_WIDTH    (32),
        .QDEPTH        (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p1_we     (p1_we),
        .p1_rd     (p1_rd),
        .p1_wd     (p1_wd),
        .p2_we     (p2_we),
        .p2_rd     (p2_rd),
        .p2_wd     (p2_wd),
        .lu_valid  (lu_valid),
        .lu_rd     (lu_rd),
        .lu_wd     (lu_wd),
        .lu_ready  (lu_ready),
        .WE3       (WE3),
        .AD3       (AD3),
        .WD3       (WD3),
        .WE6       (WE6),
        .AD6       (AD6),
        .WD6       (WD6),
        .pend_mask (pend_mask)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Monitor: compares both write ports against the expectation due this cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [63:0] act, want;
        if (WE3 && WE6) chk("port_collision", {63'b0, AD3 == AD6}, 64'd0);
        if (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk("due_cycle", 64'(e.due), 64'(cyc));
            act  = e.we3 ? {26'b0, WE3, AD3, WD3} : {63'b0, WE3};
            want = e.we3 ? {26'b0, 1'b1, e.ad3, e.wd3} : 64'd0;
            chk("port3", act, want);
            act  = e.we6 ? {26'b0, WE6, AD6, WD6} : {63'b0, WE6};
            want = e.we6 ? {26'b0, 1'b1, e.ad6, e.wd6} : 64'd0;
            chk("port6", act, want);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p(input logic a_we, input logic [4:0] a_rd, input logic [31:0] a_wd,
                         input logic b_we, input logic [4:0] b_rd, input logic [31:0] b_wd);
        p1_we = a_we; p1_rd = a_rd; p1_wd = a_wd;
        p2_we = b_we; p2_rd = b_rd; p2_wd = b_wd;
    endtask

    task automatic set_lu(input logic v, input logic [4:0] rd, input logic [31:0] wd);
        lu_valid = v; lu_rd = rd; lu_wd = wd;
    endtask

    task automatic expw(input logic x3, input logic [4:0] a3, input logic [31:0] d3,
                        input logic x6, input logic [4:0] a6, input logic [31:0] d6);
        exp_t e;
        e.due = cyc + 1;
        e.we3 = x3; e.ad3 = a3; e.wd3 = d3;
        e.we6 = x6; e.ad6 = a6; e.wd6 = d6;
        sb.push_back(e);
    endtask

    // Both ports occupied by pipeline writes to x1/x2.
    task automatic busy(input int k);
        set_p(1, 1, 32'h100 + k, 1, 2, 32'h200 + k);
        expw(1, 1, 32'h100 + k, 1, 2, 32'h200 + k);
        step();
    endtask

    task automatic idle();
        set_p(0, 0, 0, 0, 0, 0);
        set_lu(0, 0, 0);
        expw(0, 0, 0, 0, 0, 0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_p(0, 0, 0, 0, 0, 0);
        set_lu(0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", {WE3, WE6}, 0);
        chk("rst_ad", {AD3, AD6}, 0);
        chk("rst_wd", {WD3, WD6}, 0);
        chk("rst_pend", pend_mask, 0);
        chk("rst_ready", lu_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", lu_ready, 1);
        step();

        // Independent pipeline writes, then same-rd clash, rd=0 and we=0 discards.
        set_p(1, 5, 32'h11, 1, 6, 32'h22); expw(1, 5, 32'h11, 1, 6, 32'h22); step();
        idle();
        set_p(1, 7, 32'hA, 1, 7, 32'hB); expw(0, 0, 0, 1, 7, 32'hB); step();
        set_p(1, 0, 32'h33, 1, 0, 32'h44); expw(0, 0, 0, 0, 0, 0); step();
        set_p(0, 3, 32'h55, 1, 0, 32'h1); expw(0, 0, 0, 0, 0, 0); step();
        set_p(1, 3, 32'h66, 0, 0, 0); expw(1, 3, 32'h66, 0, 0, 0); step();
        idle();

        // LU write held off by three busy cycles, drained on the first free one.
        set_lu(1, 9, 32'h99);
        chk("ready_c", lu_ready, 1);
        busy(0);
        set_lu(0, 0, 0);
        chk("pend9_a", pend_mask[9], 1);
        busy(1);
        chk("pend9_b", pend_mask[9], 1);
        busy(2);
        chk("pend9_c", pend_mask[9], 1);
        set_p(0, 0, 0, 0, 0, 0); expw(1, 9, 32'h99, 0, 0, 0); step();
        chk("pend9_clr", pend_mask, 0);
        idle();

        // Fill the queue, refused offer when full, then single-port drain.
        set_lu(1, 10, 32'hA0);
        chk("ready_d0", lu_ready, 1);
        busy(3);
        set_lu(1, 11, 32'hB0);
        chk("ready_d1", lu_ready, 1);
        busy(4);
        set_lu(1, 12, 32'hC0);
        chk("ready_full", lu_ready, 0);
        busy(5);
        set_lu(0, 0, 0);
        chk("pend_full", pend_mask, (32'd1 << 10) | (32'd1 << 11));
        set_p(1, 1, 32'h77, 0, 0, 0); expw(1, 1, 32'h77, 1, 10, 32'hA0);
        chk("ready_still_full", lu_ready, 0);
        step();
        chk("ready_after_drain", lu_ready, 1);
        chk("pend_after_drain", pend_mask, 32'd1 << 11);
        set_p(0, 0, 0, 0, 0, 0); expw(1, 11, 32'hB0, 0, 0, 0); step();
        idle();
        chk("pend_d_clr", pend_mask, 0);

        // Second LU write to the same register supersedes the first.
        set_lu(1, 13, 32'h1);
        busy(6);
        set_lu(1, 13, 32'h2);
        busy(7);
        set_lu(0, 0, 0);
        chk("pend13", pend_mask, 32'd1 << 13);
        set_p(0, 0, 0, 0, 0, 0); expw(1, 13, 32'h2, 0, 0, 0); step();
        chk("pend13_clr", pend_mask, 0);

        // LU offers discarded: rd matches a same-cycle pipeline rd, and rd=0.
        set_p(1, 3, 32'h1, 1, 8, 32'h2); set_lu(1, 3, 32'h55);
        expw(1, 3, 32'h1, 1, 8, 32'h2); step();
        set_p(0, 0, 0, 0, 0, 0); set_lu(1, 0, 32'h56);
        expw(0, 0, 0, 0, 0, 0); step();
        set_lu(0, 0, 0);
        chk("pend_discard", pend_mask, 0);
        idle();

        // Queued x4 killed by a newer pipeline write to x4.
        set_lu(1, 4, 32'h1);
        busy(8);
        set_lu(0, 0, 0);
        chk("pend4", pend_mask[4], 1);
        set_p(1, 4, 32'h2, 0, 0, 0); expw(1, 4, 32'h2, 0, 0, 0); step();
        chk("pend4_clr", pend_mask, 0);
        idle();

        // Reset with two entries queued.
        set_lu(1, 20, 32'h20);
        busy(9);
        set_lu(1, 21, 32'h21);
        busy(10);
        set_lu(0, 0, 0);
        set_p(0, 0, 0, 0, 0, 0);
        chk("pend_pre_rst", pend_mask, (32'd1 << 20) | (32'd1 << 21));
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", {WE3, WE6}, 0);
        chk("mid_rst_ad_wd", {AD3, AD6, WD3 | WD6}, 0);
        chk("mid_rst_pend", pend_mask, 0);
        chk("mid_rst_ready", lu_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        idle();
        idle();
        chk("post_rst_pend", pend_mask, 0);
        chk("post_rst_ready", lu_ready, 1);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 5, register address width (32 registers).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, write-data width.
REQ-003 SHALL have parameter QDEPTH, default 2, long-latency writeback queue depth.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports p1_we/p1_rd/p1_wd  input  1/ADDRESS_WIDTH/DATA_WIDTH  pipeline-1 writeback request.
REQ-007 SHALL have ports p2_we/p2_rd/p2_wd  input  1/ADDRESS_WIDTH/DATA_WIDTH  pipeline-2 writeback request; p2 is younger in program order than p1.
REQ-008 SHALL have ports lu_valid/lu_rd/lu_wd  input  1/ADDRESS_WIDTH/DATA_WIDTH  long-latency unit (mul/div/load-miss) writeback offer.
REQ-009 SHALL have port lu_ready  output  1  queue can accept an LU writeback this cycle.
REQ-010 SHALL have ports WE3/AD3/WD3 and WE6/AD6/WD6  output  1/ADDRESS_WIDTH/DATA_WIDTH  register-file write ports 1 and 2.
REQ-011 SHALL have port pend_mask  output  2**ADDRESS_WIDTH  bit r set while a queued LU write to register r is outstanding.

Function
REQ-012 SHALL register all write-port outputs: a request sampled at edge N appears on WE3/WE6 during cycle N+1 (latency 1).
REQ-013 SHALL treat a pipeline request as effective only when its we=1 and rd!=0; rd=0 requests are discarded.
REQ-014 SHALL route effective p1 to port 3 and effective p2 to port 6.
REQ-015 SHALL, when p1 and p2 are both effective with equal rd, drop p1 (younger p2 wins), leaving port 3 free.
REQ-016 SHALL accept an LU offer when lu_valid && lu_ready; lu_ready = (occupancy < QDEPTH) from registered state, with no same-cycle dequeue credit.
REQ-017 SHALL discard an accepted LU offer with lu_rd=0, or whose lu_rd equals an effective pipeline rd in the same cycle (pipeline result is newer).
REQ-018 SHALL, on enqueue, invalidate any queued entry with the same rd (only the newest LU value per register is kept).
REQ-019 SHALL drain queued entries in FIFO order into free ports only: head to the first free port (port 3 before port 6), next entry to the remaining free port; at most 2 drains per cycle.
REQ-020 SHALL kill, without writing, any queued entry whose rd equals an effective pipeline rd in the same cycle.
REQ-021 SHALL never drive WE3=WE6=1 with AD3=AD6.
REQ-022 SHALL support simultaneous enqueue and dequeue; occupancy counter and read/write pointers wrap modulo QDEPTH.
REQ-023 SHALL derive pend_mask combinationally from valid queue entries.

Reset
REQ-024 SHALL, while rst_n=0, clear all queue entries and pointers, drive WE3=WE6=0, AD3/AD6/WD3/WD6=0, pend_mask=0, lu_ready=0.
REQ-025 SHALL drive lu_ready=1 in the first cycle after rst_n deasserts; assertion mid-operation discards queued writes.

Structure
REQ-026 SHALL place ADDRESS_WIDTH/DATA_WIDTH defaults and the queue-entry struct (valid, rd, wd) in shared package wb_pkg.
REQ-027 SHALL implement the queue as sub-module wb_queue (storage, pointers, rd-match invalidate, kill, 2-wide dequeue); port selection in wb_arbiter.

Verification
REQ-028 Bench SHALL check: p1(x5,0x11) and p2(x6,0x22) same cycle -> next cycle WE3/AD3=5/WD3=0x11, WE6/AD6=6/WD6=0x22.
REQ-029 Bench SHALL check: p1(x7,0xA) and p2(x7,0xB) -> only WE6, AD6=7, WD6=0xB; WE3=0.
REQ-030 Bench SHALL check: LU(x9,0x99) with both ports busy 3 cycles -> pend_mask[9]=1 throughout, written on first cycle a port frees, then pend_mask[9]=0.
REQ-031 Bench SHALL check: 2 LU enqueues with ports busy -> lu_ready=0; one free port -> head drains, lu_ready=1 next cycle.
REQ-032 Bench SHALL check: queued LU(x4,0x1) then p1(x4,0x2) -> only 0x2 written to x4; entry killed.
REQ-033 Bench SHALL check: rst_n pulled low with 2 entries queued -> all outputs 0 immediately, no queued write after release.
